sine_seq_ctrl: RTL and testbench

- Sequencer for the 128x10 quarter-wave sine sample ROM (registered read, 1-cycle latency).
- Runs a phase accumulator at a programmable sample rate and folds phase into a ROM address plus quadrant.
- Reconstructs the full signed sine sample from each ROM word.
- Delivers samples downstream on a valid/ready handshake and flags dropped samples; sits between the ROM and the DAC/PWM consumer.

---
 rtl/sine_seq_pkg.sv | 29 ++
 rtl/sine_tick_gen.sv | 50 +++++
 rtl/sine_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sine_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_seq_pkg.sv
// -----------------------------------------------------------------------------
// sine_seq_pkg
// Shared types and constants for the quarter-wave sine sequencer.
//   state_e      : sequencer FSM states (IDLE, RUN, DRAIN)
//   Q0..Q3       : phase quadrant codes (top QUAD_W bits of the accumulator)
//   *_DEF        : default widths / tick divider used by sine_seq_ctrl
// -----------------------------------------------------------------------------
package sine_seq_pkg;

    localparam int PHASE_W_DEF  = 16;
    localparam int ADDR_W_DEF   = 7;
    localparam int DATA_W_DEF   = 10;
    localparam int TICK_DIV_DEF = 4;
    localparam int QUAD_W       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Quadrant codes: bit 0 selects a mirrored (descending) ROM walk,
    // bit 1 selects a negated sample.
    localparam logic [QUAD_W-1:0] Q0 = 2'd0;
    localparam logic [QUAD_W-1:0] Q1 = 2'd1;
    localparam logic [QUAD_W-1:0] Q2 = 2'd2;
    localparam logic [QUAD_W-1:0] Q3 = 2'd3;

endpackage

// File: rtl/sine_tick_gen.sv
// -----------------------------------------------------------------------------
// sine_tick_gen
// Sample-rate divider: counts 0..TICK_DIV-1 while enabled and pulses tick
// whenever the count is 0, so the first enabled cycle is always a tick.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   en    in   count enable (sequencer in RUN)
//   clear in   restart the count at 0 (start accepted)
//   tick  out  sample tick, one cycle every TICK_DIV enabled cycles
// -----------------------------------------------------------------------------
module sine_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/sine_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sine_seq_ctrl
// Sequencer for a quarter-wave sine ROM (registered read, 1-cycle latency).
// A phase accumulator advances by fcw on every sample tick; its top two bits
// pick the quadrant, the next ADDR_W bits the ROM address (mirrored in odd
// quadrants). The ROM word is negated in the lower half-wave and delivered on
// a valid/ready output register; a result arriving while a sample is still
// held is dropped and flagged on the sticky overrun output.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   begin generation (IDLE only)
//   stop      in   end generation (RUN only)
//   fcw       in   frequency tuning word, sampled on each tick
//   rom_addr  out  registered ROM read address
//   rom_data  in   ROM word, valid the cycle after rom_addr
//   out_data  out  signed two's-complement sample
//   out_valid out  sample available
//   out_ready in   consumer accepts
//   overrun   out  sticky sample-dropped flag
//   clr_ovr   in   clears overrun
//   busy      out  sequencer not in IDLE
// -----------------------------------------------------------------------------
module sine_seq_ctrl
    import sine_seq_pkg::*;
#(
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [PHASE_W-1:0] fcw,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                s1_valid_q, s1_valid_d;
    logic                s1_neg_q, s1_neg_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_neg_q, s2_neg_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                start_acc;
    logic [QUAD_W-1:0]   quad;
    logic [ADDR_W-1:0]   qaddr;
    logic                mirror;
    logic                neg;
    logic [DATA_W-1:0]   result;
    logic                drop;

    assign start_acc = (state_q == IDLE) && start;

    sine_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == RUN),
        .clear (start_acc),
        .tick  (tick)
    );

    assign quad  = phase_q[PHASE_W-1 -: QUAD_W];
    assign qaddr = phase_q[PHASE_W-3 -: ADDR_W];

    always_comb begin
        mirror = 1'b0;
        neg    = 1'b0;
        case (quad)
            Q0:      begin mirror = 1'b0; neg = 1'b0; end
            Q1:      begin mirror = 1'b1; neg = 1'b0; end
            Q2:      begin mirror = 1'b0; neg = 1'b1; end
            default: begin mirror = 1'b1; neg = 1'b1; end
        endcase
    end

    // Two's-complement negate; the carry out of ~0+1 is discarded so -0 == 0.
    assign result = s2_neg_q ? DATA_W'(~rom_data + 1'b1) : rom_data;

    // A result arriving while an unaccepted sample is held is lost.
    assign drop = s2_valid_q && out_valid_q && !out_ready;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rom_addr_d  = rom_addr_q;
        s1_valid_d  = tick;
        s1_neg_d    = s1_neg_q;
        s2_valid_d  = s1_valid_q;
        s2_neg_d    = s1_neg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = DRAIN;
            // Stage 2 always empties on this edge and no ticks issue in DRAIN,
            // so the pipeline is empty once stage 1 is.
            DRAIN:   if (!s1_valid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start_acc) begin
            phase_d = '0;
        end

        if (tick) begin
            // 2**ADDR_W-1 - a is the bitwise complement of a.
            rom_addr_d = mirror ? ~qaddr : qaddr;
            s1_neg_d   = neg;
            phase_d    = phase_q + fcw;
        end

        if (s2_valid_q) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = result;
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_ovr || start_acc) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            rom_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_neg_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rom_addr_q  <= rom_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_neg_q    <= s1_neg_d;
            s2_valid_q  <= s2_valid_d;
            s2_neg_q    <= s2_neg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sine_seq_ctrl
// Self-checking bench for sine_seq_ctrl with default parameters
// (PHASE_W=16, ADDR_W=7, DATA_W=10, TICK_DIV=4) and a registered ROM model
// holding rom[a] = 4*a. Inputs change and outputs are sampled on the falling
// edge; cycle c of a run is the c-th falling edge after start is driven.
// -----------------------------------------------------------------------------
module tb_sine_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] fcw;
    logic [6:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        clr_ovr;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    sine_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .fcw       (fcw),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: rom[a] = 4*a.
    always_ff @(posedge clk) begin
        rom_data <= {1'b0, rom_addr, 2'b00};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One directed burst: tuning word, whether stop accompanies start, number
    // of samples, and the expected rom_addr / out_data for each tick.
    typedef struct packed {
        logic [15:0]     fcw;
        logic            with_stop;
        logic [2:0]      n;
        logic [0:4][6:0] addr;
        logic [0:4][9:0] data;
    } burst_t;

    function automatic burst_t mk(input logic [15:0] f, input logic ws, input logic [2:0] n,
                                  input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                                  input logic [6:0] a3, input logic [6:0] a4,
                                  input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2,
                                  input logic [9:0] d3, input logic [9:0] d4);
        burst_t b;
        b.fcw = f;
        b.with_stop = ws;
        b.n = n;
        b.addr[0] = a0; b.addr[1] = a1; b.addr[2] = a2; b.addr[3] = a3; b.addr[4] = a4;
        b.data[0] = d0; b.data[1] = d1; b.data[2] = d2; b.data[3] = d3; b.data[4] = d4;
        return b;
    endfunction

    // Start a run and check ticks at cycles 1,5,9,..: address visible one
    // cycle after the tick, sample visible three cycles after it.
    task automatic run_burst(input burst_t b, input int bi);
        int k;
        fcw       = b.fcw;
        out_ready = 1'b1;
        start     = 1'b1;
        stop      = b.with_stop;
        for (int c = 1; c <= 4 * int'(b.n); c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (c == 1) check($sformatf("busy after start b%0d", bi), busy, 1);
            if (c == 3) check($sformatf("no early valid b%0d", bi), out_valid, 0);
            if (c >= 2 && (c - 2) % 4 == 0) begin
                k = (c - 2) / 4;
                check($sformatf("rom_addr b%0d k%0d", bi, k), rom_addr, b.addr[k]);
            end
            if (c % 4 == 0) begin
                k = c / 4 - 1;
                check($sformatf("out_valid b%0d k%0d", bi, k), out_valid, 1);
                check($sformatf("out_data b%0d k%0d", bi, k), out_data, b.data[k]);
            end
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        check({"idle after drain ", tag}, busy, 0);
        check({"no valid after drain ", tag}, out_valid, 0);
    endtask

    burst_t bursts[5];
    logic   ghost;

    initial begin
        bursts[0] = mk(16'h0080, 1'b1, 3'd4, 7'd0, 7'd1,   7'd2, 7'd3,   7'd0,
                       10'h000, 10'h004, 10'h008, 10'h00C, 10'h000);
        bursts[1] = mk(16'h4000, 1'b0, 3'd5, 7'd0, 7'd127, 7'd0, 7'd127, 7'd0,
                       10'h000, 10'h1FC, 10'h000, 10'h204, 10'h000);
        bursts[2] = mk(16'h4080, 1'b0, 3'd4, 7'd0, 7'd126, 7'd2, 7'd124, 7'd0,
                       10'h000, 10'h1F8, 10'h3F8, 10'h210, 10'h000);
        bursts[3] = mk(16'h8080, 1'b0, 3'd2, 7'd0, 7'd1,   7'd0, 7'd0,   7'd0,
                       10'h000, 10'h3FC, 10'h000, 10'h000, 10'h000);
        bursts[4] = mk(16'hFF80, 1'b0, 3'd3, 7'd0, 7'd0,   7'd1, 7'd0,   7'd0,
                       10'h000, 10'h000, 10'h3FC, 10'h000, 10'h000);

        // ---- Reset with start asserted and garbage fcw ----
        rst = 1'b1; start = 1'b1; stop = 1'b0; fcw = 16'hA5C3;
        out_ready = 1'b1; clr_ovr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset rom_addr", rom_addr, 0);
            check("reset out_data", out_data, 0);
            check("reset out_valid", out_valid, 0);
            check("reset overrun", overrun, 0);
            check("reset busy", busy, 0);
        end
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("post-reset busy", busy, 0);
        check("post-reset rom_addr", rom_addr, 0);

        // ---- Table-driven sweeps / quadrant fold / wrap ----
        for (int i = 0; i < 5; i++) begin
            run_burst(bursts[i], i);
            drain($sformatf("b%0d", i));
        end

        // ---- Backpressure and overrun ----
        fcw = 16'h0080; out_ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) begin
                check("bp first valid", out_valid, 1);
                check("bp first data", out_data, 0);
                out_ready = 1'b0;
            end
            if (c >= 5 && c <= 12) begin
                check($sformatf("bp held valid c%0d", c), out_valid, 1);
                check($sformatf("bp held data c%0d", c), out_data, 0);
            end
            if (c == 7)  check("bp no overrun yet", overrun, 0);
            if (c == 8)  check("bp overrun at 2nd delivery", overrun, 1);
            if (c == 11) clr_ovr = 1'b1;
            if (c == 12) begin
                check("bp drop beats clr_ovr", overrun, 1);
                out_ready = 1'b1;
            end
            if (c == 13) begin
                clr_ovr = 1'b0;
                check("bp overrun cleared", overrun, 0);
                check("bp sample 0 accepted", out_valid, 0);
            end
            if (c == 16) begin
                check("bp next valid", out_valid, 1);
                check("bp next data", out_data, 12);
                check("bp overrun stays clear", overrun, 0);
            end
        end
        drain("bp");

        // ---- Stop in the tick cycle for address 5 ----
        fcw = 16'h0080; out_ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b1;   // ignored in DRAIN
        check("stop draining busy", busy, 1);
        check("stop last addr", rom_addr, 5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("stop idle", busy, 0);
        check("stop final valid", out_valid, 1);
        check("stop final data", out_data, 20);
        repeat (6) @(negedge clk);
        check("stop addr frozen", rom_addr, 5);
        check("stop still idle", busy, 0);
        run_burst(bursts[3], 5);
        drain("restart");

        // ---- Reset with a held sample and a fetch in flight ----
        fcw = 16'h0080; out_ready = 1'b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) check("rst-mid held valid", out_valid, 1);
            if (c == 8) check("rst-mid overrun", overrun, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst-mid out_valid", out_valid, 0);
        check("rst-mid busy", busy, 0);
        check("rst-mid overrun cleared", overrun, 0);
        check("rst-mid out_data", out_data, 0);
        ghost = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ghost = 1'b1;
        end
        check("rst-mid no ghost sample", ghost, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
